// File: rtl/axi_rt_pkg.sv
// axi_rt_pkg: byte-count width/type shared with the probes, plus the region index width helper
package axi_rt_pkg;
  localparam int unsigned NumBytesWidth = 12;
  typedef logic [NumBytesWidth-1:0] ax_bytes_t;
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/axi_rt_budget_tracker_if.sv
// axi_rt_budget_tracker_if: AW/AR handshake events (happening, region, bytes); master = probes, slave = tracker
interface axi_rt_budget_tracker_if #(
  parameter int unsigned RegionWidth = 1,
  parameter int unsigned BytesWidth  = 12
);
  logic                   aw_happening;
  logic [RegionWidth-1:0] aw_region;
  logic [BytesWidth-1:0]  aw_bytes;
  logic                   ar_happening;
  logic [RegionWidth-1:0] ar_region;
  logic [BytesWidth-1:0]  ar_bytes;
  modport master (output aw_happening, aw_region, aw_bytes, ar_happening, ar_region, ar_bytes);
  modport slave  (input  aw_happening, aw_region, aw_bytes, ar_happening, ar_region, ar_bytes);
endinterface

// File: rtl/axi_rt_budget_counter.sv
// axi_rt_budget_counter: one budget/period pair; in charge_i+bytes_i, budget_i, period_i, enable_i, abort_i; out budget_left_o, period_left_o
module axi_rt_budget_counter #(
  parameter int unsigned PeriodWidth = 32,
  parameter int unsigned BudgetWidth = 32,
  parameter int unsigned BytesWidth  = 12
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic                   abort_i,
  input  logic                   charge_i,
  input  logic [BytesWidth-1:0]  bytes_i,
  input  logic [BudgetWidth-1:0] budget_i,
  input  logic [PeriodWidth-1:0] period_i,
  output logic [BudgetWidth-1:0] budget_left_o,
  output logic [PeriodWidth-1:0] period_left_o
);
  logic [BudgetWidth-1:0] budget_left_q, budget_left_d, base, charge;
  logic [PeriodWidth-1:0] period_left_q, period_left_d;
  logic                   reload;
  always_comb begin
    reload        = abort_i || period_left_q == '0;
    charge        = charge_i ? BudgetWidth'(bytes_i) : '0;
    base          = reload ? budget_i : budget_left_q;
    budget_left_d = !enable_i ? budget_i : (charge > base ? '0 : base - charge);
    period_left_d = (!enable_i || reload) ? period_i : period_left_q - PeriodWidth'(1);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      budget_left_q <= '0;
      period_left_q <= '0;
    end else begin
      budget_left_q <= budget_left_d;
      period_left_q <= period_left_d;
    end
  end
  assign budget_left_o = budget_left_q;
  assign period_left_o = period_left_q;
endmodule

// File: rtl/axi_rt_budget_tracker.sv
// axi_rt_budget_tracker: per-region W/R budget tracking; in bus events, budgets, periods, enable_i, abort_i; out budget/period left, isolate bits
module axi_rt_budget_tracker
  import axi_rt_pkg::*;
#(
  parameter int unsigned NumAddrRegions = 2,
  parameter int unsigned PeriodWidth    = 32,
  parameter int unsigned BudgetWidth    = 32,
  parameter int unsigned BytesWidth     = NumBytesWidth,
  parameter int unsigned RegionWidth    = idx_width(NumAddrRegions)
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     enable_i,
  input  logic                                     abort_i,
  axi_rt_budget_tracker_if.slave                   bus,
  input  logic [NumAddrRegions-1:0][BudgetWidth-1:0] w_budget_i,
  input  logic [NumAddrRegions-1:0][BudgetWidth-1:0] r_budget_i,
  input  logic [NumAddrRegions-1:0][PeriodWidth-1:0] w_period_i,
  input  logic [NumAddrRegions-1:0][PeriodWidth-1:0] r_period_i,
  output logic [NumAddrRegions-1:0][BudgetWidth-1:0] w_budget_left_o,
  output logic [NumAddrRegions-1:0][BudgetWidth-1:0] r_budget_left_o,
  output logic [NumAddrRegions-1:0][PeriodWidth-1:0] w_period_left_o,
  output logic [NumAddrRegions-1:0][PeriodWidth-1:0] r_period_left_o,
  output logic [NumAddrRegions-1:0]                  w_isolate_o,
  output logic [NumAddrRegions-1:0]                  r_isolate_o,
  output logic                                       isolate_o
);
  for (genvar r = 0; r < NumAddrRegions; r++) begin : g_region
    axi_rt_budget_counter #(
      .PeriodWidth (PeriodWidth),
      .BudgetWidth (BudgetWidth),
      .BytesWidth  (BytesWidth)
    ) u_w (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .enable_i      (enable_i),
      .abort_i       (abort_i),
      .charge_i      (bus.aw_happening && bus.aw_region == RegionWidth'(r)),
      .bytes_i       (bus.aw_bytes),
      .budget_i      (w_budget_i[r]),
      .period_i      (w_period_i[r]),
      .budget_left_o (w_budget_left_o[r]),
      .period_left_o (w_period_left_o[r])
    );
    axi_rt_budget_counter #(
      .PeriodWidth (PeriodWidth),
      .BudgetWidth (BudgetWidth),
      .BytesWidth  (BytesWidth)
    ) u_r (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .enable_i      (enable_i),
      .abort_i       (abort_i),
      .charge_i      (bus.ar_happening && bus.ar_region == RegionWidth'(r)),
      .bytes_i       (bus.ar_bytes),
      .budget_i      (r_budget_i[r]),
      .period_i      (r_period_i[r]),
      .budget_left_o (r_budget_left_o[r]),
      .period_left_o (r_period_left_o[r])
    );
    assign w_isolate_o[r] = enable_i && w_budget_left_o[r] == '0;
    assign r_isolate_o[r] = enable_i && r_budget_left_o[r] == '0;
  end
  assign isolate_o = |{w_isolate_o, r_isolate_o};
endmodule
